cdb_arbiter: RTL and testbench

Common Data Bus arbiter and broadcaster for the Tomasulo back end. It collects completed results from the functional units and reservation-station writeback paths, then picks at most one per cycle with a round-robin policy. The winner is driven onto `cdb_data`, which is consumed by the reorder buffer, the reservation stations and the register-status logic. Each requester has a one-entry holding buffer with a valid/ready handshake, so a functional unit that loses arbitration is back-pressured instead of dropping its result.

---
 rtl/cdb_arbiter.sv | 123 ++++++++++++
 tb/tb_cdb_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one-entry holding buffer per functional unit, round-robin
// selection of at most one result per cycle, registered broadcast onto cdb_data.

package cdb_arbiter_pkg;
  parameter int unsigned XLEN        = 32;
  parameter int unsigned ROB_TAG_LEN = 6;

  typedef struct packed {
    logic                   valid;
    logic [ROB_TAG_LEN-1:0] rob_tag;
    logic [XLEN-1:0]        value;
  } CDB_DATA;
endpackage

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FU = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_FU-1:0]                     fu_valid,
  input  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]    fu_rob_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]           fu_value,
  output logic [NUM_FU-1:0]                     fu_ready,
  output CDB_DATA                               cdb_data,
  output logic [$clog2(NUM_FU+1)-1:0]           pending_count
);

  localparam int unsigned PtrW = $clog2(NUM_FU);
  localparam int unsigned CntW = $clog2(NUM_FU+1);
  localparam logic [PtrW:0] NumFuW = (PtrW+1)'(NUM_FU);

  logic [NUM_FU-1:0]                  buf_valid_q, buf_valid_d;
  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0] buf_tag_q, buf_tag_d;
  logic [NUM_FU-1:0][XLEN-1:0]        buf_value_q, buf_value_d;
  logic [PtrW-1:0]                    rr_ptr_q, rr_ptr_d;
  CDB_DATA                            cdb_d;
  logic [CntW-1:0]                    cnt_d;

  logic [NUM_FU-1:0] grant;
  logic [PtrW-1:0]   win;
  logic              found;
  logic [PtrW:0]     idx;

  // Scan from rr_ptr upward with an explicit wrap at NUM_FU, not at a power of two.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = {1'b0, rr_ptr_q} + (PtrW+1)'(k);
      if (idx >= NumFuW) begin
        idx = idx - NumFuW;
      end
      if (!found && buf_valid_q[idx[PtrW-1:0]]) begin
        found = 1'b1;
        win   = idx[PtrW-1:0];
      end
    end
    if (found) begin
      grant[win] = 1'b1;
    end
  end

  assign fu_ready = ~buf_valid_q | grant;

  // A granted entry drains this edge, so it may take a new result at the same time.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_value_d = buf_value_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        buf_valid_d[i] = 1'b0;
      end
      if (fu_valid[i] && fu_ready[i]) begin
        buf_valid_d[i] = 1'b1;
        buf_tag_d[i]   = fu_rob_tag[i];
        buf_value_d[i] = fu_value[i];
      end
    end
  end

  always_comb begin
    cdb_d       = cdb_data;
    cdb_d.valid = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    if (found) begin
      cdb_d.valid   = 1'b1;
      cdb_d.rob_tag = buf_tag_q[win];
      cdb_d.value   = buf_value_q[win];
      rr_ptr_d      = (win == PtrW'(NUM_FU - 1)) ? '0 : win + 1'b1;
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      cnt_d = cnt_d + CntW'(buf_valid_d[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      buf_valid_q   <= '0;
      buf_tag_q     <= '0;
      buf_value_q   <= '0;
      rr_ptr_q      <= '0;
      cdb_data      <= '0;
      pending_count <= '0;
    end else begin
      buf_valid_q   <= buf_valid_d;
      buf_tag_q     <= buf_tag_d;
      buf_value_q   <= buf_value_d;
      rr_ptr_q      <= rr_ptr_d;
      cdb_data      <= cdb_d;
      pending_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued when results are
// presented and popped as cdb_data.valid appears.

module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int unsigned NumFu = 4;

  typedef logic [ROB_TAG_LEN+XLEN-1:0] exp_t;

  logic                               clock = 1'b0;
  logic                               reset;
  logic [NumFu-1:0]                   fu_valid;
  logic [NumFu-1:0][ROB_TAG_LEN-1:0]  fu_rob_tag;
  logic [NumFu-1:0][XLEN-1:0]         fu_value;
  logic [NumFu-1:0]                   fu_ready;
  CDB_DATA                            cdb_data;
  logic [$clog2(NumFu+1)-1:0]         pending_count;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  cdb_arbiter #(.NUM_FU(NumFu)) dut (
    .clock         (clock),
    .reset         (reset),
    .fu_valid      (fu_valid),
    .fu_rob_tag    (fu_rob_tag),
    .fu_value      (fu_value),
    .fu_ready      (fu_ready),
    .cdb_data      (cdb_data),
    .pending_count (pending_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void expect_bc(input int tag, input int val);
    sb.push_back({ROB_TAG_LEN'(tag), XLEN'(val)});
  endfunction

  task automatic drive(input int unit, input int tag, input int val);
    fu_valid[unit]   = 1'b1;
    fu_rob_tag[unit] = ROB_TAG_LEN'(tag);
    fu_value[unit]   = XLEN'(val);
  endtask

  // Advance one edge, sample 1ns later, and retire any broadcast against the queue.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    if (cdb_data.valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("bcast_unexpected", 64'(cdb_data.valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("bcast", 64'({cdb_data.rob_tag, cdb_data.value}), 64'(e));
      end
    end
  endtask

  initial begin
    logic [3:0] rdy_exp [5];
    logic [NumFu-1:0] acc;
    int na, nb;
    rdy_exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};

    // Reset with every unit presenting: nothing may be captured.
    reset      = 1'b0;
    fu_valid   = 4'b1111;
    fu_rob_tag = '0;
    fu_value   = '0;
    for (int i = 0; i < 4; i++) drive(i, 9 + i, 'h900 + i);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_valid", 64'(cdb_data.valid), 64'd0);
      chk("rst_pending", 64'(pending_count), 64'd0);
    end
    reset    = 1'b1;
    fu_valid = '0;
    chk("rst_ready", 64'(fu_ready), 64'hf);
    tick();
    chk("rst_post_valid", 64'(cdb_data.valid), 64'd0);
    chk("rst_post_pending", 64'(pending_count), 64'd0);

    // Single result from unit 2.
    drive(2, 5, 'h1234);
    expect_bc(5, 'h1234);
    tick();
    chk("single_t1_valid", 64'(cdb_data.valid), 64'd0);
    chk("single_t1_pending", 64'(pending_count), 64'd1);
    fu_valid = '0;
    tick();
    chk("single_t2_valid", 64'(cdb_data.valid), 64'd1);
    chk("single_rr", 64'(dut.rr_ptr_q), 64'd3);
    tick();
    chk("single_t3_valid", 64'(cdb_data.valid), 64'd0);

    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rr_after_reset", 64'(dut.rr_ptr_q), 64'd0);

    // Full contention from rr_ptr=0.
    for (int i = 0; i < 4; i++) begin
      drive(i, i + 1, 'h100 + i);
      expect_bc(i + 1, 'h100 + i);
    end
    tick();
    fu_valid = '0;
    chk("cont_pending", 64'(pending_count), 64'd4);
    chk("cont_ready", 64'(fu_ready), 64'(rdy_exp[0]));
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("cont_valid", 64'(cdb_data.valid), 64'd1);
      chk("cont_pending", 64'(pending_count), 64'(4 - k));
      chk("cont_ready", 64'(fu_ready), 64'(rdy_exp[k]));
    end
    chk("cont_drain", 64'(sb.size()), 64'd0);

    // Round-robin wrap: grant unit 2 so rr_ptr=3, then units 0 and 3 together.
    drive(2, 7, 'h77);
    expect_bc(7, 'h77);
    tick();
    fu_valid = '0;
    tick();
    chk("wrap_rr3", 64'(dut.rr_ptr_q), 64'd3);
    drive(0, 10, 'ha0);
    drive(3, 13, 'hd3);
    expect_bc(13, 'hd3);
    expect_bc(10, 'ha0);
    tick();
    fu_valid = '0;
    chk("wrap_ready", 64'(fu_ready), 64'he);
    tick();
    tick();
    chk("wrap_rr_end", 64'(dut.rr_ptr_q), 64'd1);
    chk("wrap_drain", 64'(sb.size()), 64'd0);

    // Unit 0 streams alone at one result per cycle.
    for (int k = 1; k <= 8; k++) expect_bc(k, 'h1000 + k);
    drive(0, 1, 'h1001);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("stream_ready0", 64'(fu_ready[0]), 64'd1);
      if (k >= 2) chk("stream_valid", 64'(cdb_data.valid), 64'd1);
      if (k < 8) drive(0, k + 1, 'h1000 + k + 1);
      else fu_valid = '0;
    end
    tick();
    chk("stream_last_valid", 64'(cdb_data.valid), 64'd1);
    tick();
    chk("stream_idle_valid", 64'(cdb_data.valid), 64'd0);
    chk("stream_drain", 64'(sb.size()), 64'd0);

    // Units 0 and 1 both stream with handshake; rr_ptr=1 so unit 1 leads.
    for (int k = 0; k < 4; k++) begin
      expect_bc(30 + k, 'h3000 + k);
      expect_bc(20 + k, 'h2000 + k);
    end
    na = 0;
    nb = 0;
    drive(0, 20, 'h2000);
    drive(1, 30, 'h3000);
    for (int c = 1; c <= 12; c++) begin
      acc = fu_valid & fu_ready;
      tick();
      if (acc[0]) begin
        na++;
        if (na < 4) drive(0, 20 + na, 'h2000 + na);
        else fu_valid[0] = 1'b0;
      end
      if (acc[1]) begin
        nb++;
        if (nb < 4) drive(1, 30 + nb, 'h3000 + nb);
        else fu_valid[1] = 1'b0;
      end
      if (c <= 6) chk("alt_ready0", 64'(fu_ready[0]), 64'((c % 2) == 0));
    end
    chk("alt_drain", 64'(sb.size()), 64'd0);

    // Reset with three buffers occupied discards everything.
    drive(0, 40, 'h4000);
    drive(1, 41, 'h4100);
    drive(2, 42, 'h4200);
    tick();
    fu_valid = '0;
    chk("mid_pending", 64'(pending_count), 64'd3);
    reset = 1'b0;
    tick();
    chk("mid_valid", 64'(cdb_data.valid), 64'd0);
    chk("mid_pending0", 64'(pending_count), 64'd0);
    chk("mid_rr", 64'(dut.rr_ptr_q), 64'd0);
    reset = 1'b1;
    tick();
    chk("mid_post_valid", 64'(cdb_data.valid), 64'd0);
    tick();
    chk("mid_post_valid2", 64'(cdb_data.valid), 64'd0);
    chk("final_drain", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
